// File: rtl/spi_regfile_peripheral_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Frame width, capture-edge selection and FSM state encoding.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } spi_state_e;

  localparam int SPI_MODE0 = 0;
  localparam int SPI_MODE1 = 1;
  localparam int SPI_MODE2 = 2;
  localparam int SPI_MODE3 = 3;

  function automatic int frame_w(
    input int addr_w,
    input int data_w
  );
    return 1 + addr_w + data_w;
  endfunction

  // CPOL==CPHA samples on rising sclk
  function automatic logic capture_on_rise(
    input int mode
  );
    logic [1:0] m;
    m = 2'(mode);
    return m[1] == m[0];
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_sync.sv
// Synchroniser chain with one extra flop for edge detection.
// Resets to 0; a rise seen straight after reset is harmless to callers.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // shift the async input through the chain, keep last value for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI target with NUM_REGS x DATA_W register bank, write and read-back.
// Optional error counter at address NUM_REGS: SPI_REGFILE_ERR_CNT_EN.
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 5,
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ncs,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic CAP_RISE = capture_on_rise(SPI_MODE);
  localparam logic [ADDR_W-1:0] NREGS_A = ADDR_W'(NUM_REGS);

  logic w_ncs, w_ncs_rise, w_ncs_fall;
  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_copi;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs (
    .clk(clk), .rst_n(rst_n), .i_d(ncs),
    .o_q(w_ncs), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(sclk),
    .o_q(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_copi (
    .clk(clk), .rst_n(rst_n), .i_d(copi),
    .o_q(w_copi), .o_rise(), .o_fall()
  );

  spi_state_e r_state, w_state_nxt;

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [FRAME_W-1:0] r_sin;
  logic [DATA_W-1:0]  r_sout;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_oe;
  logic               r_cipo;
  logic               r_strobe;
  logic [ADDR_W-1:0]  r_wa;
  logic               r_err;
`ifdef SPI_REGFILE_ERR_CNT_EN
  logic [7:0]         r_err_cnt;
`endif

  logic               w_active, w_end, w_start;
  logic               w_cap, w_shf;
  logic [FRAME_W-1:0] w_sin_nxt;
  logic               w_addr_done, w_frame_done;
  logic               w_f_rw;
  logic [ADDR_W-1:0]  w_f_addr, w_rd_addr;
  logic [DATA_W-1:0]  w_f_data, w_rd_val;
  logic               w_in_bank, w_is_cnt;
  logic               w_err, w_commit, w_cnt_clr;

  // edge qualification and end-of-frame decisions; ncs rise beats sclk
  always_comb begin
    w_active  = (r_state == ADDR) || (r_state == DATA);
    w_end     = w_ncs_rise && (r_state != IDLE);
    w_start   = w_ncs_fall && (r_state == IDLE);
    w_cap     = (CAP_RISE ? w_sclk_rise : w_sclk_fall)
                && !w_ncs_rise && w_active;
    w_shf     = (CAP_RISE ? w_sclk_fall : w_sclk_rise)
                && !w_ncs_rise && r_oe;
    w_sin_nxt = {r_sin[FRAME_W-2:0], w_copi};
    w_addr_done  = w_cap && (r_state == ADDR)
                   && (r_cnt == CNT_W'(ADDR_W));
    w_frame_done = w_cap && (r_state == DATA)
                   && (r_cnt == CNT_W'(FRAME_W - 1));
    w_f_rw    = r_sin[FRAME_W-1];
    w_f_addr  = r_sin[FRAME_W-2 -: ADDR_W];
    w_f_data  = r_sin[DATA_W-1:0];
    w_rd_addr = w_sin_nxt[ADDR_W-1:0];
    w_in_bank = w_f_addr < NREGS_A;
`ifdef SPI_REGFILE_ERR_CNT_EN
    w_is_cnt  = w_f_addr == NREGS_A;
`else
    w_is_cnt  = 1'b0;
`endif
    w_err     = w_end && ((r_state != DONE)
                || (!w_in_bank && !w_is_cnt));
    w_commit  = w_end && (r_state == DONE) && w_f_rw && w_in_bank;
    w_cnt_clr = w_end && (r_state == DONE) && w_f_rw && w_is_cnt;
  end

  // read-back source for the address just completed
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_addr == ADDR_W'(i)) w_rd_val = r_regs[i];
    end
`ifdef SPI_REGFILE_ERR_CNT_EN
    if (w_rd_addr == NREGS_A) w_rd_val = DATA_W'(r_err_cnt);
`endif
  end

  // frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // frame sequencing
  always_comb begin
    w_state_nxt = r_state;
    if (w_ncs_rise) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_start) w_state_nxt = ADDR;
        ADDR: if (w_addr_done) w_state_nxt = DATA;
        DATA: if (w_frame_done) w_state_nxt = DONE;
        DONE: w_state_nxt = DONE;
      endcase
    end
  end

  // shift paths, commit, read-out and error tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs   <= '0;
      r_sin    <= '0;
      r_sout   <= '0;
      r_cnt    <= '0;
      r_oe     <= 1'b0;
      r_cipo   <= 1'b0;
      r_strobe <= 1'b0;
      r_wa     <= '0;
      r_err    <= 1'b0;
`ifdef SPI_REGFILE_ERR_CNT_EN
      r_err_cnt <= '0;
`endif
    end else begin
      r_strobe <= 1'b0;
      if (w_start) begin
        r_cnt <= '0;
        r_sin <= '0;
      end
      if (w_end) begin
        r_oe   <= 1'b0;
        r_cipo <= 1'b0;
        r_err  <= w_err;
        if (w_commit) begin
          r_strobe <= 1'b1;
          r_wa     <= w_f_addr;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_commit && w_f_addr == ADDR_W'(i)) r_regs[i] <= w_f_data;
        end
`ifdef SPI_REGFILE_ERR_CNT_EN
        if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        else if (w_cnt_clr)              r_err_cnt <= '0;
`endif
      end else if (w_cap) begin
        r_sin <= w_sin_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_addr_done) begin
          r_sout <= w_rd_val;
          r_oe   <= ~w_sin_nxt[ADDR_W];
        end
        if (w_frame_done) begin
          r_oe   <= 1'b0;
          r_cipo <= 1'b0;
        end
      end else if (w_shf) begin
        r_cipo <= r_sout[DATA_W-1];
        r_sout <= {r_sout[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign regs_q    = r_regs;
  assign cipo      = r_cipo;
  assign cipo_oe   = r_oe;
  assign wr_strobe = r_strobe;
  assign wr_addr   = r_wa;
  assign frame_err = r_err;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench: mode-0 and mode-3 targets driven by one controller model.
// Randomized frames checked against a register-bank reference model.
module tb_spi_regfile_peripheral;

  localparam int DW = 8;
  localparam int AW = 7;
  localparam int NR = 5;
  localparam time H = 80ns;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ncs = 1'b1;
  logic copi = 1'b0;
  logic sclk0 = 1'b0;
  logic sclk3 = 1'b1;

  logic cipo0, oe0, strb0, err0;
  logic cipo3, oe3, strb3, err3;
  logic [NR*DW-1:0] regs0, regs3;
  logic [AW-1:0] wa0, wa3;

  spi_regfile_peripheral #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR),
    .SPI_MODE(0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk0), .copi(copi),
    .cipo(cipo0), .cipo_oe(oe0), .regs_q(regs0), .wr_strobe(strb0),
    .wr_addr(wa0), .frame_err(err0)
  );

  spi_regfile_peripheral #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR),
    .SPI_MODE(3), .SYNC_STAGES(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk3), .copi(copi),
    .cipo(cipo3), .cipo_oe(oe3), .regs_q(regs3), .wr_strobe(strb3),
    .wr_addr(wa3), .frame_err(err3)
  );

  always #5ns clk = ~clk;

  int checks = 0;
  int errors = 0;
  int st0 = 0;
  int st3 = 0;

  always @(negedge clk) begin
    if (strb0) st0++;
    if (strb3) st3++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] m_regs [NR];
  logic          m_err;
  logic [AW-1:0] m_wa;
  int            m_cnt;

  function automatic logic [NR*DW-1:0] m_vec();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_err = 1'b0;
    m_wa  = '0;
    m_cnt = 0;
  endtask

  task automatic frame(input logic [15:0] f, input int nbits);
    logic [DW-1:0] rd0, rd3, exp_rd, d;
    logic [AW-1:0] a;
    logic rw, b, eoe, exp_err, commit;
    int oebad0, oebad3, s0, s3;
    rd0 = '0; rd3 = '0; oebad0 = 0; oebad3 = 0;
    s0 = st0; s3 = st3;
    rw = f[15];
    ncs = 1'b0;
    #(H);
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? f[15-i] : 1'($urandom_range(0, 1));
      sclk3 = 1'b0;
      copi = b;
      #(H);
      eoe = !rw && i >= 8 && i < 16;
      if (oe0 !== eoe) oebad0++;
      if (oe3 !== eoe) oebad3++;
      if (i >= 8 && i < 16) begin
        rd0 = {rd0[DW-2:0], cipo0};
        rd3 = {rd3[DW-2:0], cipo3};
      end
      sclk0 = 1'b1;
      sclk3 = 1'b1;
      #(H);
      sclk0 = 1'b0;
    end
    #(H);
    ncs = 1'b1;
    #(H);
    a = f[14:8];
    d = f[7:0];
    exp_rd = '0;
    commit = 1'b0;
    if (nbits < 16) begin
      exp_err = 1'b1;
    end else if (a < NR) begin
      exp_err = 1'b0;
      if (rw) begin
        m_regs[a] = d;
        m_wa = a;
        commit = 1'b1;
      end else begin
        exp_rd = m_regs[a];
      end
`ifdef SPI_REGFILE_ERR_CNT_EN
    end else if (a == NR) begin
      exp_err = 1'b0;
      if (rw) m_cnt = 0;
      else    exp_rd = 8'(m_cnt);
`endif
    end else begin
      exp_err = 1'b1;
    end
    if (exp_err && m_cnt < 255) m_cnt++;
    m_err = exp_err;
    chk("regs0", 64'(regs0), 64'(m_vec()));
    chk("regs3", 64'(regs3), 64'(m_vec()));
    chk("err0", 64'(err0), 64'(m_err));
    chk("err3", 64'(err3), 64'(m_err));
    chk("strobe0", 64'(st0 - s0), 64'(commit));
    chk("strobe3", 64'(st3 - s3), 64'(commit));
    chk("waddr0", 64'(wa0), 64'(m_wa));
    chk("waddr3", 64'(wa3), 64'(m_wa));
    chk("oe0", 64'(oebad0), 64'd0);
    chk("oe3", 64'(oebad3), 64'd0);
    if (!rw && nbits >= 16) begin
      chk("rdata0", 64'(rd0), 64'(exp_rd));
      chk("rdata3", 64'(rd3), 64'(exp_rd));
    end
  endtask

  function automatic logic [15:0] mk(input logic rw, input int a,
                                     input int d);
    return {rw, 7'(a), 8'(d)};
  endfunction

  initial begin
    int r, nb;
    m_reset();
    rst_n = 1'b0;
    #50ns;
    chk("rst_outs0", 64'({regs0, err0, strb0, wa0, oe0, cipo0}), 64'd0);
    chk("rst_outs3", 64'({regs3, err3, strb3, wa3, oe3, cipo3}), 64'd0);
    rst_n = 1'b1;
    #(H);

    frame(mk(1, 2, 8'hA5), 16);
    frame(mk(1, 4, 8'h3C), 16);
    frame(mk(0, 4, 0), 16);
    frame(mk(1, 5, 8'h55), 16);
    frame(mk(1, 3, 8'h96), 16);
    frame(mk(0, 6, 0), 16);
    frame(mk(1, 1, 8'h00), 10);
    frame(mk(1, 1, 8'h7E), 18);

    ncs = 1'b0;
    #(H);
    for (int i = 0; i < 12; i++) begin
      sclk3 = 1'b0;
      copi = 1'b1;
      #(H);
      sclk0 = 1'b1;
      sclk3 = 1'b1;
      #(H);
      sclk0 = 1'b0;
    end
    rst_n = 1'b0;
    #30ns;
    chk("midrst0", 64'({regs0, err0, strb0, wa0, oe0, cipo0}), 64'd0);
    chk("midrst3", 64'({regs3, err3, strb3, wa3, oe3, cipo3}), 64'd0);
    m_reset();
    rst_n = 1'b1;
    #(H);
    ncs = 1'b1;
    #(H);
    frame(mk(1, 0, 8'h11), 16);

    frame(mk(1, 2, 8'h01), 3);
    frame(mk(0, 2, 0), 7);
    frame(mk(1, 2, 8'h02), 12);
    frame(mk(0, NR, 0), 16);
    frame(mk(1, NR, 8'hFF), 16);
    frame(mk(0, NR, 0), 16);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       nb = 16;
      else if (r == 7) nb = int'($urandom_range(1, 15));
      else             nb = int'($urandom_range(17, 19));
      frame(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 255))), nb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
Parametrised SPI target exposing a bank of NUM_REGS control registers of DATA_W bits each. Supports write and read-back (CIPO) in any of the four SPI modes. All SPI pins are synchronised into clk; registers feed downstream blocks such as PWM and output-enable logic. Successor of the fixed 5×8-bit, write-only, mode-0 peripheral.

Parameters:
- DATA_W, 8, data bits per register and per frame data field.
- ADDR_W, 7, address field width.
- NUM_REGS, 5, implemented registers at addresses 0..NUM_REGS-1; must satisfy 1 ≤ NUM_REGS ≤ 2^ADDR_W - 1.
- SPI_MODE, 0, {CPOL,CPHA} encoding, 0..3.
- SYNC_STAGES, 2, flops per synchroniser chain; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ncs  in  1  chip select, active low, asynchronous to clk.
- sclk  in  1  SPI clock, asynchronous.
- copi  in  1  controller-out data, asynchronous.
- cipo  out  1  peripheral-out data; 0 when not driving.
- cipo_oe  out  1  high while a read data phase is active.
- regs_q  out  NUM_REGS*DATA_W  register bank; register i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  out  1  one-clk pulse on a committed write.
- wr_addr  out  ADDR_W  address of the last committed write; valid with wr_strobe and held afterwards.
- frame_err  out  1  sticky error flag; cleared by the next good frame.

Behaviour:
- Reset: regs_q, cipo, cipo_oe, wr_strobe, wr_addr, frame_err, shift registers and bit counter are all 0. A reset mid-frame discards the frame; the next frame starts only after a fresh ncs falling edge.
- Synchronisation: ncs, copi and sclk each pass through SYNC_STAGES flops. sclk uses one extra flop for edge detection.
  - Capture edge is rising sclk when CPOL==CPHA, falling otherwise.
  - Shift edge is the opposite edge.
  - Required clock ratio: f_sclk ≤ f_clk/8.
- Frame format, MSB first: FRAME_W = 1 + ADDR_W + DATA_W bits.
  - Bit 0 is R/W (1 = write).
  - Then ADDR_W address bits, then DATA_W data bits.
- States: IDLE, ADDR (capturing R/W and address), DATA, DONE.
  - IDLE→ADDR on synchronised ncs fall; counter cleared.
  - ADDR→DATA when 1+ADDR_W bits have been captured.
  - DATA→DONE when FRAME_W bits have been captured.
  - Any state→IDLE on synchronised ncs rise.
  - Capture edges in DONE are ignored; extra bits are discarded.
- Write commit: on synchronised ncs rise, a write commits only if state==DONE, R/W=1 and addr<NUM_REGS.
  - The register updates on that clk edge.
  - wr_strobe pulses high for exactly 1 cycle, together with wr_addr.
- Read: on the capture edge completing the address, the shift-out register loads regs_q[addr], or all-zero if addr ≥ NUM_REGS.
  - cipo_oe rises on that same clk.
  - The MSB is presented on cipo at the next shift edge, then one bit per subsequent shift edge.
  - cipo_oe falls on ncs rise or on DONE.
  - A read never changes registers.
- Errors: frame_err is set on ncs rise if any of the following holds:
  - the state was not DONE (short frame);
  - a write targeted addr ≥ NUM_REGS;
  - a read targeted addr ≥ NUM_REGS.
  A good frame of either type clears frame_err.
- Simultaneous events: if a synchronised ncs rise and an sclk edge are detected in the same cycle, the ncs rise wins and the edge is ignored.

Optional Feature:
- Macro: SPI_REGFILE_ERR_CNT_EN.
- Defined:
  - An 8-bit saturating counter increments on every cycle in which frame_err would be set.
  - The counter is readable at address NUM_REGS; it is read-only.
  - A write to NUM_REGS clears it. That write is not committed to the bank and is not flagged as an error.
  - The counter resets to 0.
- Undefined:
  - No counter exists.
  - Address NUM_REGS behaves as invalid (reads return 0 and set the error; writes are ignored and set the error).

Decomposition:
- Package spi_pkg:
  - spi_state_e enum (IDLE/ADDR/DATA/DONE);
  - SPI mode localparams;
  - function frame_w(addr_w, data_w);
  - function capture_on_rise(mode).
- One sub-module, spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs. It is instantiated for sclk; ncs and copi use the same module with edge outputs unused for copi.

Test Plan:
1. Mode 0 write addr 0x02 data 0xA5 → after ncs rise, regs_q[2]=0xA5; wr_strobe high for 1 clk; wr_addr=0x02; frame_err=0.
2. Mode 3: write 0x3C to addr 4, then read addr 4 → cipo shifts out 0x3C MSB-first on falling sclk; cipo_oe high only during the 8 data bits; regs_q unchanged.
3. Write to addr 0x05 (NUM_REGS=5) with the macro undefined → no register change, no wr_strobe, frame_err=1. Next valid write clears frame_err.
4. ncs raised after 10 of 16 bits → no register change, frame_err=1. Then send an 18-bit frame writing 0x7E to addr 1 → regs_q[1]=0x7E (2 extra bits ignored).
5. Assert rst_n low mid-frame after 12 bits, release, then send a full write of 0x11 to addr 0 → all outputs 0 during reset; no commit from the aborted frame; regs_q[0]=0x11 afterwards.
6. With SPI_REGFILE_ERR_CNT_EN defined: 3 short frames, read addr NUM_REGS → returns 0x03; write addr NUM_REGS, then read again → returns 0x00.
